// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types for the audio sample-rate scheduler
// Contents: SAMPLE_W, sample_t (one audio word), sched_state_t (scheduler FSM states).
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EFF_WAIT,
    SEND
  } sched_state_t;

endpackage

// File: rtl/audio_sched_if.sv
// rtl/audio_sched_if.sv - sample streams around the scheduler (receiver, effect, DAC)
// Signals: in_sample/in_valid from the receiver; eff_in/eff_start/eff_out to and from
// the effect block; dac_sample/dac_valid/dac_ready handshake to the DAC driver.
// Modports: master = scheduler side, slave = surrounding blocks.
interface audio_sched_if;
  import audio_pkg::*;

  sample_t in_sample;
  logic    in_valid;
  sample_t eff_in;
  logic    eff_start;
  sample_t eff_out;
  sample_t dac_sample;
  logic    dac_valid;
  logic    dac_ready;

  modport master (
    input  in_sample, in_valid, eff_out, dac_ready,
    output eff_in, eff_start, dac_sample, dac_valid
  );

  modport slave (
    output in_sample, in_valid, eff_out, dac_ready,
    input  eff_in, eff_start, dac_sample, dac_valid
  );

endinterface

// File: rtl/audio_sched_sample_fifo.sv
// rtl/audio_sched_sample_fifo.sv - synchronous first-word-fall-through sample FIFO
// Ports: clk, reset (sync, active-high), push/din write side, pop/dout read side
// (dout shows the head without a pop), level occupancy, full, empty.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  sample_t                     din,
  output sample_t                     dout,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  sample_t         mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == (AW+1)'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a write.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/audio_sched.sv
// rtl/audio_sched.sv - releases one buffered sample per output period to the DAC
// Ports: clk_25mhz, reset (sync, active-high); bus (master): receiver input, effect
// block and DAC handshake; bypass selects raw vs effect sample; primed, fifo_level,
// overrun, underrun_cnt, late_tick status; clear_flags clears the sticky status.
module audio_sched
  import audio_pkg::*;
#(
  parameter int clock_max   = 25_000_000,
  parameter int SAMPLE_RATE = 8_000,
  parameter int FIFO_DEPTH  = 8,
  parameter int EFF_LATENCY = 2
) (
  input  logic                        clk_25mhz,
  input  logic                        reset,
  audio_sched_if.master               bus,
  input  logic                        bypass,
  output logic                        primed,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overrun,
  output logic [7:0]                  underrun_cnt,
  output logic                        late_tick,
  input  logic                        clear_flags
);

  localparam int PERIOD = clock_max / SAMPLE_RATE;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int WW     = $clog2(EFF_LATENCY + 1);
  localparam int LW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] HALF      = LW'(FIFO_DEPTH / 2);
  localparam logic [CW-1:0] TICK_LAST = CW'(PERIOD - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(EFF_LATENCY - 1);

  sched_state_t  state, state_next;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [WW-1:0] wait_cnt;
  sample_t       last_sample;
  sample_t       eff_hold;
  sample_t       fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          primed_q;
  logic          underrun_evt;
  logic          overrun_evt;
  logic          late_evt;
  logic [7:0]    underrun_base;

  // Free-running output-period timer.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk_25mhz) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + 1'b1;
  end

  sample_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_25mhz),
    .reset (reset),
    .push  (bus.in_valid),
    .pop   (fifo_pop),
    .din   (bus.in_sample),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // primed is high from the very cycle the FIFO first reaches half full.
  assign primed = primed_q || (fifo_level >= HALF);

  always_ff @(posedge clk_25mhz) begin
    if (reset)                    primed_q <= 1'b0;
    else if (fifo_level >= HALF)  primed_q <= 1'b1;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    fifo_pop      = 1'b0;
    underrun_evt  = 1'b0;
    bus.eff_start = 1'b0;
    bus.dac_valid = 1'b0;
    case (state)
      IDLE: begin
        if (tick && primed) begin
          if (!fifo_empty) begin
            state_next = FETCH;
          end else begin
            state_next   = SEND;
            underrun_evt = 1'b1;
          end
        end
      end
      FETCH: begin
        fifo_pop = 1'b1;
        if (bypass) begin
          state_next = SEND;
        end else begin
          bus.eff_start = 1'b1;
          state_next    = EFF_WAIT;
        end
      end
      EFF_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_next = SEND;
      end
      SEND: begin
        bus.dac_valid = 1'b1;
        if (bus.dac_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The effect block must see the sample together with eff_start, so in FETCH
  // eff_in comes straight from the FIFO head; afterwards the popped value is held.
  assign bus.eff_in     = (state == FETCH) ? fifo_dout : eff_hold;
  assign bus.dac_sample = last_sample;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      last_sample <= '0;
      eff_hold    <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        FETCH: begin
          last_sample <= fifo_dout;
          eff_hold    <= fifo_dout;
          wait_cnt    <= '0;
        end
        EFF_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) last_sample <= bus.eff_out;
        end
        default: ;
      endcase
    end
  end

  // Status flags: a clear coinciding with a new event still records the event.
  assign overrun_evt   = bus.in_valid && fifo_full && !fifo_pop;
  assign late_evt      = tick && (state != IDLE);
  assign underrun_base = clear_flags ? 8'd0 : underrun_cnt;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      overrun      <= 1'b0;
      late_tick    <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      overrun   <= (overrun && !clear_flags) || overrun_evt;
      late_tick <= (late_tick && !clear_flags) || late_evt;
      if (underrun_evt && underrun_base != 8'hff) underrun_cnt <= underrun_base + 8'd1;
      else                                        underrun_cnt <= underrun_base;
    end
  end

endmodule

// File: tb/tb_audio_sched.sv
// tb/tb_audio_sched.sv - directed self-checking bench for audio_sched
module tb_audio_sched;
  import audio_pkg::*;

  logic       clk_25mhz = 1'b0;
  logic       reset;
  logic       bypass;
  logic       primed;
  logic [3:0] fifo_level;
  logic       overrun;
  logic [7:0] underrun_cnt;
  logic       late_tick;
  logic       clear_flags;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] pipe1, pipe2;

  audio_sched_if bus ();

  audio_sched #(
    .clock_max   (1000),
    .SAMPLE_RATE (100),
    .FIFO_DEPTH  (8),
    .EFF_LATENCY (2)
  ) dut (
    .clk_25mhz    (clk_25mhz),
    .reset        (reset),
    .bus          (bus),
    .bypass       (bypass),
    .primed       (primed),
    .fifo_level   (fifo_level),
    .overrun      (overrun),
    .underrun_cnt (underrun_cnt),
    .late_tick    (late_tick),
    .clear_flags  (clear_flags)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  // Effect model: returns input+1 two cycles after eff_start, garbage otherwise.
  always @(posedge clk_25mhz) begin
    pipe1 <= bus.eff_start ? (bus.eff_in + 16'h0001) : 16'hdead;
    pipe2 <= pipe1;
  end
  assign bus.eff_out = pipe2;

  task automatic step();
    @(posedge clk_25mhz);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bypass        = 1'b1;
    clear_flags   = 1'b0;
    bus.in_sample = 16'h0000;
    bus.in_valid  = 1'b0;
    bus.dac_ready = 1'b1;
    repeat (3) @(posedge clk_25mhz);
    #1;
    reset = 1'b0;
    cyc   = 0;

    chk("rst_dac_valid", bus.dac_valid, 0);
    chk("rst_dac_sample", bus.dac_sample, 0);
    chk("rst_eff_start", bus.eff_start, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_primed", primed, 0);
    chk("rst_flags", {overrun, late_tick, underrun_cnt}, 0);

    // Bypass streaming: ticks fall on cycles 9, 19, 29, ...
    bus.in_valid = 1'b1; bus.in_sample = 16'h1111; step();
    bus.in_sample = 16'h2222; step();
    bus.in_sample = 16'h3333; step();
    chk("prime_level3", fifo_level, 3);
    chk("prime_not_yet", primed, 0);
    bus.in_sample = 16'h4444; step();
    bus.in_valid = 1'b0;
    chk("prime_level4", fifo_level, 4);
    chk("primed_4th", primed, 1);
    goto(10); chk("byp_not_early", bus.dac_valid, 0);
    goto(11); chk("byp1_valid", bus.dac_valid, 1); chk("byp1_data", bus.dac_sample, 16'h1111);
    goto(12); chk("byp1_drop", bus.dac_valid, 0);
    goto(21); chk("byp2_valid", bus.dac_valid, 1); chk("byp2_data", bus.dac_sample, 16'h2222);
    goto(31); chk("byp3_data", bus.dac_sample, 16'h3333);
    goto(41); chk("byp4_valid", bus.dac_valid, 1); chk("byp4_data", bus.dac_sample, 16'h4444);
    chk("drained", fifo_level, 0);

    // Underrun: empty FIFO repeats the last sample and counts each tick.
    goto(50); chk("und_valid", bus.dac_valid, 1); chk("und_repeat", bus.dac_sample, 16'h4444);
    chk("und_cnt1", underrun_cnt, 1);
    goto(60); chk("und_cnt2", underrun_cnt, 2);
    goto(70); chk("und_cnt3", underrun_cnt, 3);
    goto(2580); chk("und_cnt254", underrun_cnt, 254);
    goto(2590); chk("und_cnt255", underrun_cnt, 255);
    goto(3041); chk("und_sat", underrun_cnt, 255);
    chk("no_late_yet", late_tick, 0);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("und_clear", underrun_cnt, 0);
    goto(3050); chk("und_after_clr", underrun_cnt, 1);
    goto(3059); clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("clr_event_wins", underrun_cnt, 1);

    // Effect path.
    goto(3061);
    bus.in_valid = 1'b1; bus.in_sample = 16'h0100; bypass = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("eff_level", fifo_level, 1);
    goto(3070); chk("eff_start", bus.eff_start, 1); chk("eff_in", bus.eff_in, 16'h0100);
    step(); chk("eff_start_1cyc", bus.eff_start, 0);
    goto(3072); chk("eff_not_early", bus.dac_valid, 0);
    goto(3073); chk("eff_valid", bus.dac_valid, 1); chk("eff_data", bus.dac_sample, 16'h0101);

    // Overrun: nine writes between ticks.
    goto(3080);
    bypass = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_sample = 16'ha000 + 16'(i);
      if (i == 7) chk("ovr_level7", fifo_level, 7);
      if (i == 8) begin
        chk("ovr_level8", fifo_level, 8);
        chk("ovr_not_yet", overrun, 0);
      end
      step();
    end
    bus.in_valid = 1'b0;
    chk("ovr_set", overrun, 1);
    chk("ovr_level_held", fifo_level, 8);
    goto(3090); clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("ovr_clear", overrun, 0);
    chk("ovr_head_valid", bus.dac_valid, 1);
    chk("ovr_head_data", bus.dac_sample, 16'ha000);

    // Backpressure.
    step(); bus.dac_ready = 1'b0;
    goto(3101); chk("bp_valid", bus.dac_valid, 1); chk("bp_data", bus.dac_sample, 16'ha001);
    goto(3109); chk("bp_late_before", late_tick, 0);
    goto(3110); chk("bp_late_set", late_tick, 1); chk("bp_hold_valid", bus.dac_valid, 1);
    goto(3125); chk("bp_hold_valid2", bus.dac_valid, 1); chk("bp_hold_data", bus.dac_sample, 16'ha001);
    goto(3126); bus.dac_ready = 1'b1; step();
    chk("bp_released", bus.dac_valid, 0);
    bus.dac_ready = 1'b0;
    goto(3131); chk("bp_next_data", bus.dac_sample, 16'ha002); chk("bp_next_valid", bus.dac_valid, 1);

    // Reset in SEND.
    goto(3132);
    chk("rs_valid_before", bus.dac_valid, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rs_valid", bus.dac_valid, 0);
    chk("rs_level", fifo_level, 0);
    chk("rs_primed", primed, 0);
    chk("rs_flags", {overrun, late_tick, underrun_cnt}, 0);
    cyc = 0;
    bus.dac_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_sample = 16'hb001; step();
    bus.in_sample = 16'hb002; step();
    bus.in_sample = 16'hb003; step();
    bus.in_valid = 1'b0;
    goto(11);
    chk("rs_unprimed_quiet", bus.dac_valid, 0);
    chk("rs_unprimed_primed", primed, 0);
    chk("rs_unprimed_und", underrun_cnt, 0);
    goto(12); bus.in_valid = 1'b1; bus.in_sample = 16'hb004; step(); bus.in_valid = 1'b0;
    chk("rs_reprimed", primed, 1);
    goto(21); chk("rs_first_valid", bus.dac_valid, 1); chk("rs_first_data", bus.dac_sample, 16'hb001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
